// File: rtl/mips_mc_controller_pkg.sv
// Shared definitions for the MIPS multicycle controller.
// Holds the field widths, opcode/funct constants, ALU operation codes,
// datapath select codes, the FSM state encoding and the control vector
// that the output decoder produces for each state.
package mips_defs;

    localparam int OP_W    = 6;
    localparam int FN_W    = 6;
    localparam int ALUOP_W = 3;

    // Opcodes (IR[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type funct codes (IR[5:0])
    localparam logic [FN_W-1:0] FN_JR  = 6'b001000;
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;
    localparam logic [ALUOP_W-1:0] ALU_PASSA = 3'b110;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_A      = 2'b11;

    // Destination register select
    localparam logic [1:0] WR_RT  = 2'b00;
    localparam logic [1:0] WR_RD  = 2'b01;
    localparam logic [1:0] WR_R31 = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXE, S_R_WB, S_I_EXE, S_I_WB, S_BEQ, S_JUMP, S_JAL_1,
        S_JAL_2, S_JR
    } state_t;

    typedef struct packed {
        logic               pc_write;
        logic               pc_write_con;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic [1:0]         reg_wr_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
    } ctrl_t;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle controller and the datapath.
// master: controller side (takes opcode/func, drives every strobe/select).
// slave : datapath side (drives opcode/func from IR, consumes controls).
interface mips_mc_controller_if #(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 3
);
    logic [OP_W-1:0]    opcode;
    logic [FN_W-1:0]    func;
    logic               PCWrite;
    logic               PCWriteCon;
    logic               IorD;
    logic               mem_read;
    logic               mem_write;
    logic               IR_write;
    logic               RegDst;
    logic [1:0]         RegWrDst;
    logic               reg_write;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         pc_src;
    logic               illegal_op;
    logic [3:0]         state_dbg;

    modport master (
        input  opcode, func,
        output PCWrite, PCWriteCon, IorD, mem_read, mem_write, IR_write,
               RegDst, RegWrDst, reg_write, ALUSrcA, ALUSrcB, alu_op,
               pc_src, illegal_op, state_dbg
    );

    modport slave (
        output opcode, func,
        input  PCWrite, PCWriteCon, IorD, mem_read, mem_write, IR_write,
               RegDst, RegWrDst, reg_write, ALUSrcA, ALUSrcB, alu_op,
               pc_src, illegal_op, state_dbg
    );
endinterface

// File: rtl/mips_mc_controller_out_decode.sv
// Moore output decode: maps the current FSM state to the datapath control
// vector. Purely combinational.
// Ports: state (current state), slti (I_EXE performs slt instead of add),
//        ctrl (control vector; everything not set for a state is 0).
module mips_mc_out_decode
    import mips_defs::*;
(
    input  state_t state,
    input  logic   slti,
    output ctrl_t  ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = PC_ALU;
            end
            S_DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_wr_dst = WR_RT;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_wr_dst = WR_RD;
            end
            S_I_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = slti ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_wr_dst = WR_RT;
            end
            S_BEQ: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = SRCB_B;
                ctrl.alu_op       = ALU_SUB;
                ctrl.pc_write_con = 1'b1;
                ctrl.pc_src       = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            S_JAL_1: begin
                // ALUOut <= PC (already PC+4) for the link write.
                ctrl.alu_op = ALU_PASSA;
            end
            S_JAL_2: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_wr_dst = WR_R31;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_JUMP;
            end
            S_JR: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_A;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mips_mc_controller.sv
// MIPS multicycle control FSM. Sequences the datapath and the shared
// instruction/data memory; outputs are a function of state only, except
// the illegal_op pulse raised in DECODE for unsupported opcode/funct.
// Ports: clk, rst (synchronous, active high; forces all outputs to 0),
//        bus (master side of the controller/datapath control interface).
module mips_mc_controller
    import mips_defs::*;
#(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 3
) (
    input logic                clk,
    input logic                rst,
    mips_mc_controller_if.master bus
);
    state_t state_q, state_d;
    logic   is_sw_q, is_slti_q;
    logic   illegal;
    logic   legal_r;
    ctrl_t  ctrl_dec, ctrl;

    // State register. The lw/sw and addi/slti distinctions are captured in
    // DECODE so that later states never look at the IR fields again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            is_sw_q   <= 1'b0;
            is_slti_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                is_sw_q   <= (bus.opcode == OP_SW);
                is_slti_q <= (bus.opcode == OP_SLTI);
            end
        end
    end

    always_comb begin
        legal_r = 1'b0;
        case (bus.func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal_r = 1'b1;
            default:                               legal_r = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.func == FN_JR) state_d = S_JR;
                        else if (legal_r)      state_d = S_R_EXE;
                        else                   illegal = 1'b1;
                    end
                    OP_LW, OP_SW:     state_d = S_MEM_ADR;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXE;
                    OP_BEQ:           state_d = S_BEQ;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL_1;
                    default:          illegal = 1'b1;
                endcase
            end
            S_MEM_ADR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = S_MEM_WB;
            S_R_EXE:   state_d = S_R_WB;
            S_I_EXE:   state_d = S_I_WB;
            S_JAL_1:   state_d = S_JAL_2;
            default:   state_d = S_FETCH;
        endcase
    end

    mips_mc_out_decode u_dec (
        .state (state_q),
        .slti  (is_slti_q),
        .ctrl  (ctrl_dec)
    );

    // Output gating: reset suppresses every strobe in the cycle it is seen,
    // so an aborted instruction never writes memory, PC or registers.
    always_comb begin
        ctrl = ctrl_dec;
        if (rst) ctrl = '0;
    end

    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.PCWriteCon = ctrl.pc_write_con;
    assign bus.IorD       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.IR_write   = ctrl.ir_write;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.RegWrDst   = ctrl.reg_wr_dst;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.alu_op     = ALUOP_W'(ctrl.alu_op);
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.illegal_op = illegal & ~rst;
    assign bus.state_dbg  = rst ? 4'd0 : state_q;
endmodule
